// File: rtl/maze_pkg.sv
// Shared definitions for the maze cell RAM arbiter.
// Holds the cell codes, the grid geometry, the requester ids, the arbiter
// state encoding, and the read-ownership tag that travels alongside each RAM read.
package maze_pkg;

    localparam int COORD_W   = 5;
    localparam int DATA_W    = 3;
    localparam int GRID_SIZE = 24;

    typedef enum logic [2:0] {
        OCCUPIED      = 3'd0,
        AVAILABLE     = 3'd1,
        START         = 3'd2,
        END           = 3'd3,
        YOUR_POSITION = 3'd4
    } cell_e;

    typedef enum logic [1:0] {
        CHK = 2'd0,
        DRW = 2'd1,
        WR  = 2'd2
    } req_id_e;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } arb_state_e;

    // Ownership of one in-flight read: who asked for it, and whether the
    // coordinate lay outside the grid (in that case the RAM data is discarded).
    typedef struct packed {
        logic    valid;
        req_id_e who;
        logic    oob;
    } rd_tag_t;

endpackage

// File: rtl/maze_rd_tag_pipe.sv
// Read tag delay line.
// Delays the {valid, who, oob} tag of each issued read by DEPTH cycles so that
// it lines up with the RAM read data. The asynchronous clear drops every
// in-flight tag, so a read cut short by reset never produces a response.
// Ports:
//   clock   - rising-edge clock
//   reset   - asynchronous active-high clear
//   tag_in  - tag of the read issued in the current cycle (valid=0 when none)
//   tag_out - tag whose read data is on the RAM output this cycle
module maze_rd_tag_pipe
    import maze_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic    clock,
    input  logic    reset,
    input  rd_tag_t tag_in,
    output rd_tag_t tag_out
);

    rd_tag_t stage_q [DEPTH];
    rd_tag_t stage_d [DEPTH];

    // Shift by one stage per cycle, new tag entering at stage 0
    always_comb begin
        stage_d[0] = tag_in;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Tag storage with asynchronous clear
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= {$bits(rd_tag_t){1'b0}};
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    assign tag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/maze_mem_arbiter.sv
// Maze cell RAM arbiter.
// Shares one single-port cell RAM between the move-legality checker (chk), the
// redraw scanner (drw) and the player-marker writer (wr). One access is issued
// every two cycles: an IDLE cycle samples requests and registers the winner, the
// following ISSUE cycle presents the grant and the RAM address. Read data comes
// back RD_LATENCY cycles after the grant, steered to its owner. Coordinates
// outside the grid behave as walls: reads return OCCUPIED, writes are dropped.
// Ports:
//   clock, reset                      - clock, asynchronous active-high reset
//   chk_req/x/y, chk_gnt              - checker read request and grant pulse
//   chk_rvalid, chk_rdata             - checker read response
//   drw_req/x/y, drw_gnt, drw_rvalid, drw_rdata - same for the redraw scanner
//   wr_req/x/y/data, wr_gnt           - marker write request and grant pulse
//   mem_addr, mem_wren, mem_wdata     - RAM command ({y,x} address)
//   mem_rdata                         - RAM read data
module maze_mem_arbiter #(
    parameter int COORD_W    = 5,
    parameter int DATA_W     = 3,
    parameter int GRID_SIZE  = 24,
    parameter int RD_LATENCY = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 chk_req,
    input  logic [COORD_W-1:0]   chk_x,
    input  logic [COORD_W-1:0]   chk_y,
    output logic                 chk_gnt,
    output logic                 chk_rvalid,
    output logic [DATA_W-1:0]    chk_rdata,
    input  logic                 drw_req,
    input  logic [COORD_W-1:0]   drw_x,
    input  logic [COORD_W-1:0]   drw_y,
    output logic                 drw_gnt,
    output logic                 drw_rvalid,
    output logic [DATA_W-1:0]    drw_rdata,
    input  logic                 wr_req,
    input  logic [COORD_W-1:0]   wr_x,
    input  logic [COORD_W-1:0]   wr_y,
    input  logic [DATA_W-1:0]    wr_data,
    output logic                 wr_gnt,
    output logic [2*COORD_W-1:0] mem_addr,
    output logic                 mem_wren,
    output logic [DATA_W-1:0]    mem_wdata,
    input  logic [DATA_W-1:0]    mem_rdata
);

    import maze_pkg::*;

    localparam logic [COORD_W-1:0] GRID_LIM = COORD_W'(GRID_SIZE);

    arb_state_e           state_q, state_d;
    req_id_e              rr_last_q, rr_last_d;
    logic                 last_wr_q, last_wr_d;
    logic                 chk_gnt_q, chk_gnt_d;
    logic                 drw_gnt_q, drw_gnt_d;
    logic                 wr_gnt_q, wr_gnt_d;
    logic                 mem_wren_q, mem_wren_d;
    logic                 oob_q, oob_d;
    logic [2*COORD_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]    mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]    chk_rdata_q, chk_rdata_d;
    logic [DATA_W-1:0]    drw_rdata_q, drw_rdata_d;

    logic                 chk_oob, drw_oob, wr_oob, read_pending;
    logic [DATA_W-1:0]    rd_value;
    rd_tag_t              tag_in, tag_out;

    // Unsigned compare: a coordinate that underflowed to all-ones is out of grid too.
    assign chk_oob      = (chk_x >= GRID_LIM) || (chk_y >= GRID_LIM);
    assign drw_oob      = (drw_x >= GRID_LIM) || (drw_y >= GRID_LIM);
    assign wr_oob       = (wr_x  >= GRID_LIM) || (wr_y  >= GRID_LIM);
    assign read_pending = chk_req || drw_req;

    // Arbiter FSM: choose a winner in IDLE, present it for one ISSUE cycle
    always_comb begin
        state_d     = state_q;
        rr_last_d   = rr_last_q;
        last_wr_d   = last_wr_q;
        chk_gnt_d   = 1'b0;
        drw_gnt_d   = 1'b0;
        wr_gnt_d    = 1'b0;
        mem_wren_d  = 1'b0;
        oob_d       = oob_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            IDLE: begin
                if (read_pending || wr_req) begin
                    state_d = ISSUE;
                    // A write yields once after a write grant if a read is waiting.
                    if (wr_req && !(last_wr_q && read_pending)) begin
                        wr_gnt_d    = 1'b1;
                        mem_addr_d  = {wr_y, wr_x};
                        mem_wdata_d = wr_data;
                        mem_wren_d  = !wr_oob;
                        oob_d       = wr_oob;
                        last_wr_d   = 1'b1;
                    end else if (chk_req && (!drw_req || rr_last_q == DRW)) begin
                        chk_gnt_d   = 1'b1;
                        mem_addr_d  = {chk_y, chk_x};
                        oob_d       = chk_oob;
                        rr_last_d   = CHK;
                        last_wr_d   = 1'b0;
                    end else begin
                        drw_gnt_d   = 1'b1;
                        mem_addr_d  = {drw_y, drw_x};
                        oob_d       = drw_oob;
                        rr_last_d   = DRW;
                        last_wr_d   = 1'b0;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Tag for the read presented this cycle (grants are only high in ISSUE)
    always_comb begin
        tag_in.valid = chk_gnt_q || drw_gnt_q;
        tag_in.oob   = oob_q;
        if (drw_gnt_q) begin
            tag_in.who = DRW;
        end else begin
            tag_in.who = CHK;
        end
    end

    maze_rd_tag_pipe #(
        .DEPTH (RD_LATENCY)
    ) u_tag_pipe (
        .clock   (clock),
        .reset   (reset),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    assign chk_rvalid = tag_out.valid && (tag_out.who == CHK);
    assign drw_rvalid = tag_out.valid && (tag_out.who == DRW);

    // Response steering: RAM data passes straight through in the rvalid cycle
    // (the RAM latency already covers the pipe), otherwise the last value is held.
    always_comb begin
        if (tag_out.oob) begin
            rd_value = DATA_W'(OCCUPIED);
        end else begin
            rd_value = mem_rdata;
        end
        if (chk_rvalid) begin
            chk_rdata_d = rd_value;
        end else begin
            chk_rdata_d = chk_rdata_q;
        end
        if (drw_rvalid) begin
            drw_rdata_d = rd_value;
        end else begin
            drw_rdata_d = drw_rdata_q;
        end
    end

    // Arbiter and response registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            rr_last_q   <= DRW;
            last_wr_q   <= 1'b0;
            chk_gnt_q   <= 1'b0;
            drw_gnt_q   <= 1'b0;
            wr_gnt_q    <= 1'b0;
            mem_wren_q  <= 1'b0;
            oob_q       <= 1'b0;
            mem_addr_q  <= {(2*COORD_W){1'b0}};
            mem_wdata_q <= {DATA_W{1'b0}};
            chk_rdata_q <= {DATA_W{1'b0}};
            drw_rdata_q <= {DATA_W{1'b0}};
        end else begin
            state_q     <= state_d;
            rr_last_q   <= rr_last_d;
            last_wr_q   <= last_wr_d;
            chk_gnt_q   <= chk_gnt_d;
            drw_gnt_q   <= drw_gnt_d;
            wr_gnt_q    <= wr_gnt_d;
            mem_wren_q  <= mem_wren_d;
            oob_q       <= oob_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            chk_rdata_q <= chk_rdata_d;
            drw_rdata_q <= drw_rdata_d;
        end
    end

    assign chk_gnt   = chk_gnt_q;
    assign drw_gnt   = drw_gnt_q;
    assign wr_gnt    = wr_gnt_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wren  = mem_wren_q;
    assign mem_wdata = mem_wdata_q;
    assign chk_rdata = chk_rdata_d;
    assign drw_rdata = drw_rdata_d;

endmodule

// File: tb/tb_maze_mem_arbiter.sv
// Directed bench for maze_mem_arbiter. u1 uses a 1-cycle RAM, u2 a 2-cycle RAM;
// both see the same requests. Inputs change and outputs are sampled on negedges.
module tb_maze_mem_arbiter;

    logic       clock = 1'b0;
    logic       reset;
    logic       chk_req, drw_req, wr_req;
    logic [4:0] chk_x, chk_y, drw_x, drw_y, wr_x, wr_y;
    logic [2:0] wr_data;

    logic       chk_gnt1, chk_rvalid1, drw_gnt1, drw_rvalid1, wr_gnt1, mem_wren1;
    logic [2:0] chk_rdata1, drw_rdata1, mem_wdata1, mem_rdata1;
    logic [9:0] mem_addr1;
    logic       chk_gnt2, chk_rvalid2, drw_gnt2, drw_rvalid2, wr_gnt2, mem_wren2;
    logic [2:0] chk_rdata2, drw_rdata2, mem_wdata2, mem_rdata2, rd2_stage;
    logic [9:0] mem_addr2;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    maze_mem_arbiter #(.COORD_W(5), .DATA_W(3), .GRID_SIZE(24), .RD_LATENCY(1)) u1 (
        .clock(clock), .reset(reset),
        .chk_req(chk_req), .chk_x(chk_x), .chk_y(chk_y), .chk_gnt(chk_gnt1),
        .chk_rvalid(chk_rvalid1), .chk_rdata(chk_rdata1),
        .drw_req(drw_req), .drw_x(drw_x), .drw_y(drw_y), .drw_gnt(drw_gnt1),
        .drw_rvalid(drw_rvalid1), .drw_rdata(drw_rdata1),
        .wr_req(wr_req), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data), .wr_gnt(wr_gnt1),
        .mem_addr(mem_addr1), .mem_wren(mem_wren1), .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1));

    maze_mem_arbiter #(.COORD_W(5), .DATA_W(3), .GRID_SIZE(24), .RD_LATENCY(2)) u2 (
        .clock(clock), .reset(reset),
        .chk_req(chk_req), .chk_x(chk_x), .chk_y(chk_y), .chk_gnt(chk_gnt2),
        .chk_rvalid(chk_rvalid2), .chk_rdata(chk_rdata2),
        .drw_req(drw_req), .drw_x(drw_x), .drw_y(drw_y), .drw_gnt(drw_gnt2),
        .drw_rvalid(drw_rvalid2), .drw_rdata(drw_rdata2),
        .wr_req(wr_req), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data), .wr_gnt(wr_gnt2),
        .mem_addr(mem_addr2), .mem_wren(mem_wren2), .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2));

    // Fixed RAM contents: {5,3}=1, {7,6}=2, {2,1}=4, everything else END (3)
    function automatic logic [2:0] ram_val(input logic [9:0] a);
        case (a)
            10'h0A3: return 3'd1;
            10'h0E6: return 3'd2;
            10'h041: return 3'd4;
            default: return 3'd3;
        endcase
    endfunction

    always @(posedge clock) begin
        mem_rdata1 <= ram_val(mem_addr1);
        rd2_stage  <= ram_val(mem_addr2);
        mem_rdata2 <= rd2_stage;
    end

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        chk_req = 1'b0; drw_req = 1'b0; wr_req = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clock);
        checks++; if ({chk_gnt1, drw_gnt1, wr_gnt1, chk_rvalid1, drw_rvalid1, mem_wren1} !== 6'b0) begin failures++; $display("FAIL reset_ctl1: got %b expected 000000", {chk_gnt1, drw_gnt1, wr_gnt1, chk_rvalid1, drw_rvalid1, mem_wren1}); end
        checks++; if ({mem_addr1, mem_wdata1, chk_rdata1, drw_rdata1} !== 19'd0) begin failures++; $display("FAIL reset_data1: got %h expected 0", {mem_addr1, mem_wdata1, chk_rdata1, drw_rdata1}); end
        checks++; if ({chk_gnt2, drw_gnt2, wr_gnt2, chk_rvalid2, drw_rvalid2, mem_wren2} !== 6'b0) begin failures++; $display("FAIL reset_ctl2: got %b expected 000000", {chk_gnt2, drw_gnt2, wr_gnt2, chk_rvalid2, drw_rvalid2, mem_wren2}); end
        checks++; if ({mem_addr2, mem_wdata2, chk_rdata2, drw_rdata2} !== 19'd0) begin failures++; $display("FAIL reset_data2: got %h expected 0", {mem_addr2, mem_wdata2, chk_rdata2, drw_rdata2}); end
        reset = 1'b0;
        @(negedge clock);
        checks++; if ({chk_gnt1, drw_gnt1, wr_gnt1, chk_rvalid1, drw_rvalid1, mem_wren1} !== 6'b0) begin failures++; $display("FAIL idle_no_req: got %b expected 000000", {chk_gnt1, drw_gnt1, wr_gnt1, chk_rvalid1, drw_rvalid1, mem_wren1}); end
    endtask

    task automatic test_single_read();
        do_reset();
        chk_x = 5'd3; chk_y = 5'd5; chk_req = 1'b1;
        @(negedge clock);
        checks++; if ({chk_gnt1, drw_gnt1, wr_gnt1, mem_wren1} !== 4'b1000) begin failures++; $display("FAIL t1_gnt: got %b expected 1000", {chk_gnt1, drw_gnt1, wr_gnt1, mem_wren1}); end
        checks++; if (mem_addr1 !== 10'h0A3) begin failures++; $display("FAIL t1_addr: got %h expected 0a3", mem_addr1); end
        chk_req = 1'b0;
        @(negedge clock);
        checks++; if ({chk_gnt1, chk_rvalid1, drw_rvalid1} !== 3'b010) begin failures++; $display("FAIL t1_rvalid: got %b expected 010", {chk_gnt1, chk_rvalid1, drw_rvalid1}); end
        checks++; if (chk_rdata1 !== 3'd1) begin failures++; $display("FAIL t1_rdata: got %0d expected 1", chk_rdata1); end
        @(negedge clock);
        checks++; if ({chk_gnt1, chk_rvalid1, chk_rdata1} !== 5'b00001) begin failures++; $display("FAIL t1_hold: got %b expected 00001", {chk_gnt1, chk_rvalid1, chk_rdata1}); end
    endtask

    task automatic test_arbitration_order();
        logic [2:0] exp_g;
        logic [1:0] exp_v;
        do_reset();
        wr_x = 5'd10; wr_y = 5'd9; wr_data = 3'd4;
        chk_x = 5'd1; chk_y = 5'd2; drw_x = 5'd6; drw_y = 5'd7;
        wr_req = 1'b1; chk_req = 1'b1; drw_req = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clock);
            exp_g = (c == 1) ? 3'b100 : (c == 3) ? 3'b010 : (c == 5) ? 3'b001 : 3'b000;
            exp_v = (c == 4) ? 2'b10 : (c == 6) ? 2'b01 : 2'b00;
            checks++; if ({wr_gnt1, chk_gnt1, drw_gnt1} !== exp_g) begin failures++; $display("FAIL t2_gnt c%0d: got %b expected %b", c, {wr_gnt1, chk_gnt1, drw_gnt1}, exp_g); end
            checks++; if ({chk_rvalid1, drw_rvalid1} !== exp_v) begin failures++; $display("FAIL t2_rvalid c%0d: got %b expected %b", c, {chk_rvalid1, drw_rvalid1}, exp_v); end
            if (c == 1) begin
                checks++; if ({mem_wren1, mem_addr1, mem_wdata1} !== {1'b1, 10'h12A, 3'd4}) begin failures++; $display("FAIL t2_write: got %b/%h/%0d expected 1/12a/4", mem_wren1, mem_addr1, mem_wdata1); end
            end
            if (c == 3) begin
                checks++; if ({mem_wren1, mem_addr1} !== {1'b0, 10'h041}) begin failures++; $display("FAIL t2_chk_addr: got %b/%h expected 0/041", mem_wren1, mem_addr1); end
            end
            if (c == 4) begin
                checks++; if (chk_rdata1 !== 3'd4) begin failures++; $display("FAIL t2_chk_rdata: got %0d expected 4", chk_rdata1); end
            end
            if (c == 5) begin
                checks++; if (mem_addr1 !== 10'h0E6) begin failures++; $display("FAIL t2_drw_addr: got %h expected 0e6", mem_addr1); end
            end
            if (c == 6) begin
                checks++; if ({drw_rdata1, chk_rdata1} !== {3'd2, 3'd4}) begin failures++; $display("FAIL t2_drw_rdata: got %0d/%0d expected 2/4", drw_rdata1, chk_rdata1); end
            end
            if (wr_gnt1) wr_req = 1'b0;
            if (chk_gnt1) chk_req = 1'b0;
            if (drw_gnt1) drw_req = 1'b0;
        end
    endtask

    task automatic test_write_fairness();
        logic [1:0] exp_g;
        do_reset();
        wr_x = 5'd2; wr_y = 5'd2; wr_data = 3'd2; chk_x = 5'd1; chk_y = 5'd2;
        wr_req = 1'b1; chk_req = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clock);
            exp_g = (c % 4 == 1) ? 2'b10 : (c % 4 == 3) ? 2'b01 : 2'b00;
            checks++; if ({wr_gnt1, chk_gnt1} !== exp_g) begin failures++; $display("FAIL t3_alt c%0d: got %b expected %b", c, {wr_gnt1, chk_gnt1}, exp_g); end
        end
        wr_req = 1'b0; chk_req = 1'b0;
    endtask

    task automatic test_out_of_bounds();
        logic [4:0] xs [5] = '{5'd3, 5'd31, 5'd24, 5'd7, 5'd23};
        logic [4:0] ys [5] = '{5'd5, 5'd0, 5'd7, 5'd24, 5'd23};
        logic [9:0] as [5] = '{10'h0A3, 10'h01F, 10'h0F8, 10'h307, 10'h2F7};
        logic [2:0] ds [5] = '{3'd1, 3'd0, 3'd0, 3'd0, 3'd3};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            chk_x = xs[i]; chk_y = ys[i]; chk_req = 1'b1;
            @(negedge clock);
            checks++; if ({chk_gnt1, mem_addr1} !== {1'b1, as[i]}) begin failures++; $display("FAIL t4_gnt v%0d: got %b/%h expected 1/%h", i, chk_gnt1, mem_addr1, as[i]); end
            chk_req = 1'b0;
            @(negedge clock);
            checks++; if ({chk_rvalid1, chk_rdata1} !== {1'b1, ds[i]}) begin failures++; $display("FAIL t4_rdata v%0d: got %b/%0d expected 1/%0d", i, chk_rvalid1, chk_rdata1, ds[i]); end
        end
        wr_x = 5'd24; wr_y = 5'd0; wr_data = 3'd4; wr_req = 1'b1;
        @(negedge clock);
        checks++; if ({wr_gnt1, mem_wren1, mem_addr1} !== {1'b1, 1'b0, 10'h018}) begin failures++; $display("FAIL t4_wr_oob: got %b/%b/%h expected 1/0/018", wr_gnt1, mem_wren1, mem_addr1); end
        wr_req = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_g, exp_v;
        do_reset();
        chk_x = 5'd3; chk_y = 5'd5; drw_x = 5'd6; drw_y = 5'd7;
        chk_req = 1'b1; drw_req = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clock);
            exp_g = (c == 1) ? 2'b10 : (c == 3) ? 2'b01 : 2'b00;
            exp_v = (c == 3) ? 2'b10 : (c == 5) ? 2'b01 : 2'b00;
            checks++; if ({chk_gnt2, drw_gnt2} !== exp_g) begin failures++; $display("FAIL t5_gnt c%0d: got %b expected %b", c, {chk_gnt2, drw_gnt2}, exp_g); end
            checks++; if ({chk_rvalid2, drw_rvalid2} !== exp_v) begin failures++; $display("FAIL t5_rvalid c%0d: got %b expected %b", c, {chk_rvalid2, drw_rvalid2}, exp_v); end
            if (c == 3) begin
                checks++; if (chk_rdata2 !== 3'd1) begin failures++; $display("FAIL t5_chk_rdata: got %0d expected 1", chk_rdata2); end
            end
            if (c == 5) begin
                checks++; if ({chk_rdata2, drw_rdata2} !== {3'd1, 3'd2}) begin failures++; $display("FAIL t5_drw_rdata: got %0d/%0d expected 1/2", chk_rdata2, drw_rdata2); end
            end
            if (chk_gnt2) chk_req = 1'b0;
            if (drw_gnt2) drw_req = 1'b0;
        end
    endtask

    task automatic test_reset_mid_access();
        chk_x = 5'd3; chk_y = 5'd5; chk_req = 1'b1;
        @(negedge clock);
        checks++; if (chk_gnt1 !== 1'b1) begin failures++; $display("FAIL t6_gnt: got %b expected 1", chk_gnt1); end
        chk_req = 1'b0;
        reset = 1'b1;
        #1;
        checks++; if ({chk_gnt1, drw_gnt1, wr_gnt1, chk_rvalid1, drw_rvalid1, mem_wren1} !== 6'b0) begin failures++; $display("FAIL t6_ctl_in_reset: got %b expected 000000", {chk_gnt1, drw_gnt1, wr_gnt1, chk_rvalid1, drw_rvalid1, mem_wren1}); end
        checks++; if ({mem_addr1, mem_wdata1, chk_rdata1, drw_rdata1} !== 19'd0) begin failures++; $display("FAIL t6_data_in_reset: got %h expected 0", {mem_addr1, mem_wdata1, chk_rdata1, drw_rdata1}); end
        drw_x = 5'd6; drw_y = 5'd7; chk_req = 1'b1; drw_req = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clock);
            checks++; if ({chk_gnt1, chk_rvalid1} !== 2'b00) begin failures++; $display("FAIL t6_no_rvalid c%0d: got %b expected 00", c, {chk_gnt1, chk_rvalid1}); end
        end
        reset = 1'b0;
        @(negedge clock);
        checks++; if ({chk_gnt1, drw_gnt1} !== 2'b10) begin failures++; $display("FAIL t6_first_after_reset: got %b expected 10", {chk_gnt1, drw_gnt1}); end
        chk_req = 1'b0;
        @(negedge clock);
        checks++; if ({chk_rvalid1, chk_rdata1} !== {1'b1, 3'd1}) begin failures++; $display("FAIL t6_read_after_reset: got %b/%0d expected 1/1", chk_rvalid1, chk_rdata1); end
        drw_req = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        reset = 1'b1;
        chk_req = 1'b0; drw_req = 1'b0; wr_req = 1'b0;
        chk_x = 5'd0; chk_y = 5'd0; drw_x = 5'd0; drw_y = 5'd0;
        wr_x = 5'd0; wr_y = 5'd0; wr_data = 3'd0;
        test_reset();
        test_single_read();
        test_arbitration_order();
        test_write_fairness();
        test_out_of_bounds();
        test_back_to_back();
        test_reset_mid_access();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
